// File: rtl/back_memory_pkg.sv
// Shared types for the background-memory arbiter: arbitration states, default widths, stat helper.
package back_memory_pkg;

  localparam int BG_ADDR_W = 13;
  localparam int BG_DATA_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_FORCE = 2'd3
  } arb_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/back_mem_wbuf.sv
// Write buffer: synchronous FIFO, head visible combinationally, push/pop take effect at the clock edge.
// Push is ignored when full and pop when empty; simultaneous push+pop keeps the count.
module back_mem_wbuf #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = entries[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) entries[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/back_memory_arbiter.sv
// Single-port background memory arbiter: reads first, buffered writes, forced write after STARVE_LIMIT denials.
// Read data RD_LATENCY cycles after grant; writes back-pressured by wr_full. Optional stats: BACK_MEMORY_ARB_STATS_EN.
module back_memory_arbiter
  import back_memory_pkg::*;
#(
  parameter int ADDR_W       = BG_ADDR_W,
  parameter int DATA_W       = BG_DATA_W,
  parameter int WBUF_DEPTH   = 4,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_full,
  output logic              wr_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              idle
`ifdef BACK_MEMORY_ARB_STATS_EN
  ,
  input  logic              stat_clear,
  output logic [15:0]       stat_reads,
  output logic [15:0]       stat_writes,
  output logic [15:0]       stat_forced
`endif
);

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]         wb_count;
  logic                     wb_full;
  logic                     wb_empty;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  arb_state_t               state;
  arb_state_t               next_state;
  logic [SC_W-1:0]          starve_cnt;
  logic [RD_LATENCY-1:0]    rd_pipe;
  logic [ADDR_W-1:0]        last_addr;
  logic [DATA_W-1:0]        last_data;
  logic                     wr_issue;

  back_mem_wbuf #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clock    (clock),
    .reset    (reset),
    .push     (wr_ack),
    .push_dat ({wr_addr, wr_data}),
    .pop      (wr_issue),
    .head_dat ({head_addr, head_data}),
    .count    (wb_count),
    .full     (wb_full),
    .empty    (wb_empty)
  );

  always_comb begin
    next_state = ST_IDLE;
    if (reset)
      next_state = ST_IDLE;
    else if (starve_cnt == STARVE_MAX && !wb_empty)
      next_state = ST_FORCE;
    else if (rd_req)
      next_state = ST_RD;
    else if (!wb_empty)
      next_state = ST_WR;
  end

  assign rd_gnt   = (next_state == ST_RD);
  assign wr_issue = (next_state == ST_WR) || (next_state == ST_FORCE);
  assign mem_wren = wr_issue;
  assign wr_ack   = wr_req & ~wb_full;
  assign wr_full  = wb_full;

  // Idle cycles keep the last address/data on the bus to avoid needless toggling.
  always_comb begin
    mem_address = last_addr;
    mem_data    = last_data;
    if (reset) begin
      mem_address = '0;
      mem_data    = '0;
    end else if (rd_gnt) begin
      mem_address = rd_addr;
    end else if (wr_issue) begin
      mem_address = head_addr;
      mem_data    = head_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      rd_pipe    <= '0;
      last_addr  <= '0;
      last_data  <= '0;
    end else begin
      state     <= next_state;
      rd_pipe   <= (rd_pipe << 1) | RD_LATENCY'(rd_gnt);
      last_addr <= mem_address;
      last_data <= mem_data;
      case (next_state)
        ST_WR, ST_FORCE: starve_cnt <= '0;
        ST_RD: if (!wb_empty && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_valid = rd_pipe[RD_LATENCY-1];
  assign rd_data  = mem_q;
  assign wr_done  = (state == ST_WR) || (state == ST_FORCE);
  assign idle     = (wb_count == '0) & ~|rd_pipe;

`ifdef BACK_MEMORY_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_forced <= '0;
    end else if (stat_clear) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_forced <= '0;
    end else begin
      if (next_state == ST_RD)    stat_reads  <= sat_inc(stat_reads);
      if (wr_issue)               stat_writes <= sat_inc(stat_writes);
      if (next_state == ST_FORCE) stat_forced <= sat_inc(stat_forced);
    end
  end
`endif

endmodule

// File: tb/tb_back_memory_arbiter.sv
// Directed bench for back_memory_arbiter with a 2-cycle registered memory model.
module tb_back_memory_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [12:0] rd_addr = '0;
  logic        rd_gnt;
  logic        rd_valid;
  logic [8:0]  rd_data;
  logic        wr_req = 1'b0;
  logic [12:0] wr_addr = '0;
  logic [8:0]  wr_data = '0;
  logic        wr_ack;
  logic        wr_full;
  logic        wr_done;
  logic [12:0] mem_address;
  logic [8:0]  mem_data;
  logic        mem_wren;
  logic [8:0]  mem_q = '0;
  logic        idle;
`ifdef BACK_MEMORY_ARB_STATS_EN
  logic        stat_clear = 1'b0;
  logic [15:0] stat_reads;
  logic [15:0] stat_writes;
  logic [15:0] stat_forced;
`endif

  logic [8:0]  bmem [8192];
  logic [12:0] mem_a_r = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  back_memory_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .wr_full     (wr_full),
    .wr_done     (wr_done),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .idle        (idle)
`ifdef BACK_MEMORY_ARB_STATS_EN
    ,
    .stat_clear  (stat_clear),
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_forced (stat_forced)
`endif
  );

  // Memory wrapper model: registered address, registered q.
  always @(posedge clock) begin
    mem_a_r <= mem_address;
    if (mem_wren) bmem[mem_address] <= mem_data;
    mem_q <= bmem[mem_a_r];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_chk(input string tag, input logic [12:0] a, input logic [8:0] exp);
    @(negedge clock);
    rd_req = 1'b1; rd_addr = a; #1;
    check({tag, "_gnt"}, 32'(rd_gnt), 32'd1);
    @(negedge clock);
    rd_req = 1'b0; #1;
    check({tag, "_early"}, 32'(rd_valid), 32'd0);
    @(negedge clock); #1;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    logic seen;
    logic exp_force;
    for (int i = 0; i < 8192; i++) bmem[i] = 9'(i + 'h40);

    // Outputs held quiet during reset, even with a read request present.
    repeat (2) @(negedge clock);
    rd_req = 1'b1; rd_addr = 13'h55; #1;
    check("rst_idle",  32'(idle),        32'd1);
    check("rst_wren",  32'(mem_wren),    32'd0);
    check("rst_addr",  32'(mem_address), 32'd0);
    check("rst_data",  32'(mem_data),    32'd0);
    check("rst_gnt",   32'(rd_gnt),      32'd0);
    check("rst_full",  32'(wr_full),     32'd0);
    check("rst_valid", 32'(rd_valid),    32'd0);
    @(negedge clock);
    rd_req = 1'b0; reset = 1'b0;

    // Reset in the cycle after a read grant abandons the read.
    @(negedge clock);
    rd_req = 1'b1; rd_addr = 13'h0010; #1;
    check("t1_gnt",  32'(rd_gnt),      32'd1);
    check("t1_addr", 32'(mem_address), 32'h10);
    @(negedge clock);
    rd_req = 1'b0; reset = 1'b1; #1;
    seen = rd_valid;
    repeat (2) begin @(negedge clock); #1; seen |= rd_valid; end
    reset = 1'b0;
    repeat (4) begin @(negedge clock); #1; seen |= rd_valid; end
    check("t1_no_valid", 32'(seen),    32'd0);
    check("t1_full",     32'(wr_full), 32'd0);
    check("t1_idle",     32'(idle),    32'd1);

    // Single buffered write, committed the cycle after push, then read back.
    @(negedge clock);
    wr_req = 1'b1; wr_addr = 13'h0100; wr_data = 9'h1FF; #1;
    check("t2_ack",   32'(wr_ack),   32'd1);
    check("t2_wren0", 32'(mem_wren), 32'd0);
    @(negedge clock);
    wr_req = 1'b0; #1;
    check("t2_wren",  32'(mem_wren),    32'd1);
    check("t2_addr",  32'(mem_address), 32'h100);
    check("t2_data",  32'(mem_data),    32'h1FF);
    check("t2_busy",  32'(idle),        32'd0);
    @(negedge clock); #1;
    check("t2_done",  32'(wr_done),  32'd1);
    check("t2_wren1", 32'(mem_wren), 32'd0);
    @(negedge clock); #1;
    check("t2_done0", 32'(wr_done), 32'd0);
    check("t2_idle",  32'(idle),    32'd1);
    read_chk("t2_rb", 13'h0100, 9'h1FF);

    // Fill under continuous reads, then starvation forces one write every 9 cycles.
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      rd_req = 1'b1; rd_addr = 13'h0020;
      wr_req = (k <= 5); wr_addr = 13'(13'h0200 + k - 1); wr_data = 9'(k); #1;
      if (k <= 5) check("t3_ack", 32'(wr_ack), 32'(k <= 4));
      if (k == 5) check("t3_full", 32'(wr_full), 32'd1);
      if (k == 11) check("t4_done", 32'(wr_done), 32'd1);
      exp_force = (k == 10) || (k == 19) || (k == 28);
      check("t4_gnt",  32'(rd_gnt),   32'(!exp_force));
      check("t4_wren", 32'(mem_wren), 32'(exp_force));
      if (exp_force) begin
        check("t4_faddr", 32'(mem_address), 32'(13'h0200 + (k - 10) / 9));
        check("t4_fdata", 32'(mem_data),    32'((k - 10) / 9 + 1));
      end
    end
    @(negedge clock);
    rd_req = 1'b0; wr_req = 1'b0; #1;
    check("t4_drain_wren", 32'(mem_wren),    32'd1);
    check("t4_drain_addr", 32'(mem_address), 32'h203);
    check("t4_drain_data", 32'(mem_data),    32'h4);
    read_chk("t3_rejected", 13'h0204, 9'h044);

    // Push during a pop with two entries queued; commit order must follow push order.
    @(negedge clock);
    rd_req = 1'b1; rd_addr = 13'h0005;
    wr_req = 1'b1; wr_addr = 13'h0300; wr_data = 9'h011; #1;
    check("t5_ack_a", 32'(wr_ack), 32'd1);
    @(negedge clock);
    wr_addr = 13'h0301; wr_data = 9'h022; #1;
    check("t5_ack_b", 32'(wr_ack), 32'd1);
    check("t5_gnt",   32'(rd_gnt), 32'd1);
    @(negedge clock);
    rd_req = 1'b0; wr_addr = 13'h0302; wr_data = 9'h033; #1;
    check("t5_ack_c",  32'(wr_ack),      32'd1);
    check("t5_wren_a", 32'(mem_wren),    32'd1);
    check("t5_addr_a", 32'(mem_address), 32'h300);
    check("t5_data_a", 32'(mem_data),    32'h011);
    @(negedge clock);
    wr_req = 1'b0; #1;
    check("t5_full",   32'(wr_full),     32'd0);
    check("t5_wren_b", 32'(mem_wren),    32'd1);
    check("t5_addr_b", 32'(mem_address), 32'h301);
    check("t5_data_b", 32'(mem_data),    32'h022);
    @(negedge clock); #1;
    check("t5_wren_c", 32'(mem_wren),    32'd1);
    check("t5_addr_c", 32'(mem_address), 32'h302);
    check("t5_data_c", 32'(mem_data),    32'h033);
    check("t5_busy",   32'(idle),        32'd0);
    @(negedge clock); #1;
    check("t5_empty", 32'(mem_wren), 32'd0);
    check("t5_idle",  32'(idle),     32'd1);

    // Back-to-back reads of addresses 0..3.
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      rd_req = (i < 4); rd_addr = 13'(i); #1;
      if (i < 4) check("t6_gnt", 32'(rd_gnt), 32'd1);
      check("t6_valid", 32'(rd_valid), 32'(i >= 2 && i < 6));
      if (i >= 2 && i < 6) check("t6_data", 32'(rd_data), 32'('h40 + i - 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/back_memory_arbiter.md
Name: back_memory_arbiter

Overview:
- Shares the single-port background memory between two requesters:
  - the display read path (pixel fetch, latency-sensitive);
  - the instruction-decoder write path (bursty, tolerant).
- Sits between the decoder/VGA logic and the memory wrapper; drives its address/data/wren and consumes its registered q.
- Buffers writes in a small FIFO and issues at most one memory access per clock.
- Reads have priority; a starvation guard guarantees write progress.

Parameters:
- ADDR_W, 13, memory address width (8192 words).
- DATA_W, 9, colour word width (RGB 3-3-3).
- WBUF_DEPTH, 4, write-buffer entries (power of two, ≥2).
- RD_LATENCY, 2, cycles from read grant to valid data at mem_q.
- STARVE_LIMIT, 8, consecutive cycles a non-empty write buffer may be denied before a forced write.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rd_req  in  1  display read request; held until granted.
- rd_addr  in  ADDR_W  read address.
- rd_gnt  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  rd_data valid (registered pulse).
- rd_data  out  DATA_W  read data (mem_q passed through when rd_valid=1).
- wr_req  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  write accepted into buffer (combinational, = wr_req & ~wr_full).
- wr_full  out  1  buffer full (registered count == WBUF_DEPTH).
- wr_done  out  1  registered one-cycle pulse after a buffered write is committed to memory.
- mem_address  out  ADDR_W  to memory.
- mem_data  out  DATA_W  to memory.
- mem_wren  out  1  to memory.
- mem_q  in  DATA_W  from memory (registered inside the memory wrapper).
- idle  out  1  buffer empty and no read in flight.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - FIFO pointers and count (wr_full=0);
  - starvation counter;
  - read-valid shift register (rd_valid=0);
  - wr_done=0; state=ST_IDLE.
- While reset is asserted: idle=1, mem_wren=0, mem_address=0, mem_data=0. An access in flight is abandoned and no rd_valid is emitted for it.
- States:
  - ST_IDLE: nothing granted.
  - ST_RD: read issued.
  - ST_WR: buffered write issued.
  - ST_FORCE: write issued while rd_req was pending.
  - The state register records the last cycle's decision; the decision itself is combinational from current inputs and the registered count/counter.
- Arbitration, each cycle:
  - starve_cnt==STARVE_LIMIT and buffer non-empty → ST_FORCE: write the FIFO head, rd_gnt=0, starve_cnt←0.
  - else rd_req → ST_RD: rd_gnt=1, mem_address=rd_addr, mem_wren=0. If the buffer is non-empty, starve_cnt increments, saturating at STARVE_LIMIT.
  - else buffer non-empty → ST_WR: mem_address/mem_data=FIFO head, mem_wren=1, pop, starve_cnt←0.
  - else → ST_IDLE: mem_wren=0, mem_address holds last value.
- Read pipeline:
  - rd_valid asserts exactly RD_LATENCY cycles after the rd_gnt cycle.
  - Back-to-back grants give back-to-back rd_valid, in order.
  - rd_data=mem_q.
- wr_done pulses one cycle after each ST_WR/ST_FORCE cycle.
- FIFO:
  - push when wr_ack;
  - wr_full is computed from the registered count, so a push is rejected when full even if a pop happens the same cycle;
  - push and pop in the same cycle on a non-full, non-empty buffer leaves count unchanged;
  - pointers wrap modulo WBUF_DEPTH.
- A write to the address currently being read is not forwarded. A read issued before the write's commit cycle returns the old data.
- idle = (count==0) & ~|rd_valid_pipe.

Optional Feature:
- Macro: BACK_MEMORY_ARB_STATS_EN.
- When defined, adds outputs:
  - stat_reads[15:0], stat_writes[15:0], stat_forced[15:0]: saturating counters of ST_RD, ST_WR+ST_FORCE and ST_FORCE cycles;
  - stat_clear (in, 1): synchronous clear.
  - All counters reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package back_memory_pkg holds:
  - state enum (ST_IDLE, ST_RD, ST_WR, ST_FORCE);
  - default widths BG_ADDR_W=13, BG_DATA_W=9.
- Natural sub-module: back_mem_wbuf (synchronous FIFO with push/pop/count/full/empty). Arbiter, starvation counter and read-valid shift register stay in the top.

Test Plan:
- Reset mid-read:
  - grant rd_addr=0x0010, assert reset next cycle → rd_valid never rises; wr_full=0, idle=1 after release.
- Write only, no reads:
  - push (0x0100,0x1FF) → mem_wren=1 with mem_address=0x0100, mem_data=0x1FF the cycle after push;
  - wr_done one cycle later;
  - readback at 0x0100 gives rd_data=0x1FF two cycles after grant.
- Fill buffer:
  - rd_req held high, push 5 writes → first 4 wr_ack=1, 5th wr_ack=0, wr_full=1.
- Starvation:
  - rd_req continuously high with a non-empty buffer → exactly one ST_FORCE write after 8 read grants;
  - rd_gnt=0 in that cycle; the pattern repeats every 9 cycles.
- Simultaneous push/pop:
  - count=2, wr_req high during an ST_WR cycle → count stays 2, FIFO order preserved on commit (addresses written in push order).
- Back-to-back reads:
  - addresses 0,1,2,3 granted consecutively → rd_valid high 4 consecutive cycles starting at cycle+2, data in order.
